// File: rtl/button_reader_pkg.sv
// button_reader_pkg: register map and default constants shared by the button reader, bus decoder and firmware
package button_reader_pkg;

    typedef enum logic {
        REG_LEVEL = 1'b0,
        REG_EVENT = 1'b1
    } reg_addr_t;

    localparam int DEFAULT_DEBOUNCE = 16;
    localparam int RD_WIDTH         = 32;

endpackage

// File: rtl/button_reader_debounce_bit.sv
// debounce_bit: two-flop synchronizer plus hold-time debouncer for one push-button
module debounce_bit #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic stable,
    output logic stable_next
);

    localparam int CW = $clog2(DEBOUNCE);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt, cnt_next;

    // stable_next is exported so the parent can see a rising edge in the cycle it is accepted
    always_comb begin
        stable_next = (sync2 != stable && cnt == LAST) ? sync2 : stable;
        cnt_next    = (sync2 == stable || cnt == LAST) ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= button;
            sync2  <= sync1;
            stable <= stable_next;
            cnt    <= cnt_next;
        end
    end

endmodule

// File: rtl/button_reader.sv
// button_reader: debounced push-button levels and clear-on-read press events behind a CPU read port
module button_reader
    import button_reader_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [WIDTH-1:0]    BUTTONS,
    input  logic                RD_EN,
    input  logic                RD_ADDR,
    output logic [RD_WIDTH-1:0] RD_DATA,
    output logic                RD_VALID,
    output logic                IRQ
);

    logic [WIDTH-1:0] stable, stable_next, events, events_next, clr_mask, rd_sel;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_db
            debounce_bit #(.DEBOUNCE(DEBOUNCE)) u_db (
                .clk        (CLK),
                .rst        (RESET),
                .button     (BUTTONS[i]),
                .stable     (stable[i]),
                .stable_next(stable_next[i])
            );
        end
    endgenerate

    // only the bits actually returned are cleared, so a rise landing with the read survives
    always_comb begin
        clr_mask    = (RD_EN && RD_ADDR == REG_EVENT) ? events : '0;
        events_next = (events & ~clr_mask) | (stable_next & ~stable);
        rd_sel      = (RD_ADDR == REG_EVENT) ? events : stable;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            events   <= '0;
            IRQ      <= 1'b0;
            RD_VALID <= 1'b0;
            RD_DATA  <= '0;
        end else begin
            events   <= events_next;
            IRQ      <= |events_next;
            RD_VALID <= RD_EN;
            if (RD_EN)
                RD_DATA <= RD_WIDTH'(rd_sel);
        end
    end

endmodule
